// File: rtl/decode_seq_pkg.sv
// Shared types for the MU0 sequencer: state encoding, opcode values, legal range.
// No timing of its own; consumed by decode_op and decode_seq.
package decode_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC1,
    S_EXEC2,
    S_SHIFT,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JMI = 4'h5;
  localparam logic [3:0] OP_JEQ = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_LSL = 4'h9;
  localparam logic [3:0] OP_LSR = 4'hA;

  localparam logic [3:0] OP_LEGAL_MAX = 4'hA;
  localparam int NUM_OPS = 11;

endpackage

// File: rtl/decode_op.sv
// Combinational opcode -> one-hot instruction decode; zero latency, no flow control.
// An all-zero op_hot means the opcode is illegal (upper bits set or beyond OP_LEGAL_MAX).
module decode_op
  import decode_seq_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0]    op,
  output logic [NUM_OPS-1:0] op_hot
);

  logic legal;

  assign legal = ((op >> 4) == '0) && (op[3:0] <= OP_LEGAL_MAX);

  always_comb begin
    op_hot = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      op_hot[i] = legal && (op[3:0] == 4'(i));
    end
  end

endmodule

// File: rtl/decode_seq.sv
// MU0 instruction sequencer + strobe decoder: 2/3/1+shamt cycles per instruction, run leaves HALT.
// DECODE_ILLEGAL_TRAP_EN: illegal opcodes halt and set a sticky flag; otherwise they are NOPs.
module decode_seq
  import decode_seq_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int SHAMT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [OP_W-1:0]    op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               EQ,
  input  logic               MI,
  output logic               fetch,
  output logic               exec1,
  output logic               exec2,
  output logic               shifting,
  output logic               halted,
  output logic               pc_sload,
  output logic               pc_cnt_en,
  output logic               mux1_sel,
  output logic               mux2_sel,
  output logic               mux3_sel,
  output logic               IR_en,
  output logic               RAM_wren,
  output logic               shiftreg_en,
  output logic               shiftreg_load,
  output logic               shiftreg_dir,
  output logic               alu_add_sub,
  output logic               illegal
);

  logic [NUM_OPS-1:0] op_hot;

  decode_op #(.OP_W(OP_W)) u_decode_op (
    .op     (op),
    .op_hot (op_hot)
  );

  logic is_lda, is_sta, is_add, is_sub, is_jmp, is_jmi;
  logic is_jeq, is_stp, is_ldi, is_lsl, is_lsr;
  logic is_shift, shamt_nz, shamt_ge2, trap;

  assign is_lda    = op_hot[OP_LDA];
  assign is_sta    = op_hot[OP_STA];
  assign is_add    = op_hot[OP_ADD];
  assign is_sub    = op_hot[OP_SUB];
  assign is_jmp    = op_hot[OP_JMP];
  assign is_jmi    = op_hot[OP_JMI];
  assign is_jeq    = op_hot[OP_JEQ];
  assign is_stp    = op_hot[OP_STP];
  assign is_ldi    = op_hot[OP_LDI];
  assign is_lsl    = op_hot[OP_LSL];
  assign is_lsr    = op_hot[OP_LSR];
  assign is_shift  = is_lsl | is_lsr;
  assign shamt_nz  = (shamt != '0);
  assign shamt_ge2 = (shamt > SHAMT_W'(1));

  state_t             state;
  logic [SHAMT_W-1:0] cnt;

  // EXEC1 performs the first shift step, so cnt holds the remaining SHIFT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_HALT;
      cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC1;
        S_EXEC1: begin
          if (is_lda | is_add | is_sub) begin
            state <= S_EXEC2;
          end else if (is_shift && shamt_ge2) begin
            state <= S_SHIFT;
            cnt   <= shamt - SHAMT_W'(1);
          end else if (is_stp || trap) begin
            state <= S_HALT;
          end else begin
            state <= S_FETCH;
          end
        end
        S_EXEC2: state <= S_FETCH;
        S_SHIFT: begin
          cnt <= cnt - SHAMT_W'(1);
          if (cnt <= SHAMT_W'(1)) begin
            state <= S_FETCH;
          end
        end
        S_HALT: begin
          if (run) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  assign trap = ~|op_hot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state == S_EXEC1 && trap) begin
      illegal_q <= 1'b1;
    end else if (state == S_HALT && run) begin
      illegal_q <= 1'b0;
    end
  end

  assign illegal = illegal_q;
`else
  assign trap    = 1'b0;
  assign illegal = 1'b0;
`endif

  assign fetch    = (state == S_FETCH);
  assign exec1    = (state == S_EXEC1);
  assign exec2    = (state == S_EXEC2);
  assign shifting = (state == S_SHIFT);
  assign halted   = (state == S_HALT);

  always_comb begin
    pc_sload      = 1'b0;
    pc_cnt_en     = 1'b0;
    mux1_sel      = 1'b0;
    mux2_sel      = 1'b0;
    mux3_sel      = 1'b0;
    IR_en         = 1'b0;
    RAM_wren      = 1'b0;
    shiftreg_en   = 1'b0;
    shiftreg_load = 1'b0;
    shiftreg_dir  = 1'b0;
    alu_add_sub   = 1'b0;
    case (state)
      S_FETCH: begin
        mux1_sel  = 1'b1;
        IR_en     = 1'b1;
        pc_cnt_en = 1'b1;
      end
      S_EXEC1: begin
        RAM_wren      = is_sta;
        pc_sload      = is_jmp | (is_jmi & MI) | (is_jeq & EQ);
        mux2_sel      = is_ldi;
        shiftreg_load = is_ldi;
        shiftreg_en   = is_ldi | (is_shift & shamt_nz);
        shiftreg_dir  = is_lsr & shamt_nz;
      end
      S_EXEC2: begin
        shiftreg_en   = 1'b1;
        shiftreg_load = 1'b1;
        mux3_sel      = is_add | is_sub;
        alu_add_sub   = is_add;
      end
      S_SHIFT: begin
        shiftreg_en  = 1'b1;
        shiftreg_dir = is_lsr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decode_seq.sv
// Randomised scoreboard bench for decode_seq: per-cycle expected strobes are queued by the
// stimulus from the instruction table and compared by an independent monitor at each negedge.
module tb_decode_seq;

  logic       clk = 1'b0;
  logic       rst, run, EQ, MI;
  logic [3:0] op, shamt;
  logic fetch, exec1, exec2, shifting, halted, pc_sload, pc_cnt_en, mux1_sel, mux2_sel;
  logic mux3_sel, IR_en, RAM_wren, shiftreg_en, shiftreg_load, shiftreg_dir, alu_add_sub, illegal;

  always #5 clk = ~clk;

  decode_seq #(.OP_W(4), .SHAMT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .shamt(shamt), .EQ(EQ), .MI(MI),
    .fetch(fetch), .exec1(exec1), .exec2(exec2), .shifting(shifting), .halted(halted),
    .pc_sload(pc_sload), .pc_cnt_en(pc_cnt_en), .mux1_sel(mux1_sel), .mux2_sel(mux2_sel),
    .mux3_sel(mux3_sel), .IR_en(IR_en), .RAM_wren(RAM_wren), .shiftreg_en(shiftreg_en),
    .shiftreg_load(shiftreg_load), .shiftreg_dir(shiftreg_dir), .alu_add_sub(alu_add_sub),
    .illegal(illegal)
  );

  typedef struct packed {
    logic fetch, exec1, exec2, shifting, halted, pc_sload, pc_cnt_en, mux1_sel, mux2_sel;
    logic mux3_sel, ir_en, ram_wren, sr_en, sr_load, sr_dir, alu_add_sub, illegal;
  } outv_t;

  typedef struct {
    outv_t v;
    string tag;
  } exp_t;

  outv_t dut_v;
  assign dut_v = {fetch, exec1, exec2, shifting, halted, pc_sload, pc_cnt_en, mux1_sel, mux2_sel,
                  mux3_sel, IR_en, RAM_wren, shiftreg_en, shiftreg_load, shiftreg_dir,
                  alu_add_sub, illegal};

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic exp_ill = 1'b0;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (dut_v !== mon_e.v) begin
          errors++;
          $display("FAIL %s got=%h exp=%h at %0t", mon_e.tag, dut_v, mon_e.v, $time);
        end
      end
    end
  end

  task automatic step(input outv_t v, input string tag);
    exp_t e;
    e.v         = v;
    e.v.illegal = exp_ill;
    e.tag       = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic outv_t halt_v();
    outv_t v = '0;
    v.halted = 1'b1;
    return v;
  endfunction

  task automatic rand_bus();
    op    = 4'($urandom);
    shamt = 4'($urandom);
    EQ    = 1'($urandom);
    MI    = 1'($urandom);
  endtask

  task automatic leave_halt();
    int n = $urandom_range(0, 3);
    repeat (n) begin
      rand_bus();
      run = 1'b0;
      step(halt_v(), "halt_idle");
    end
    rand_bus();
    run = 1'b1;
    step(halt_v(), "halt_run");
    exp_ill = 1'b0;
  endtask

  // One instruction from FETCH until the next FETCH; rst_at > 0 resets on that SHIFT cycle.
  task automatic do_instr(input logic [3:0] o, input logic [3:0] sa, input logic eq,
                          input logic mi, input int rst_at);
    outv_t v;
    bit    is_sh = (o == 4'h9) || (o == 4'hA);
    rand_bus();
    run = 1'($urandom);
    v = '0; v.fetch = 1; v.mux1_sel = 1; v.ir_en = 1; v.pc_cnt_en = 1;
    step(v, "fetch");

    op = o; shamt = sa; EQ = eq; MI = mi; run = 1'($urandom);
    v = '0; v.exec1 = 1;
    case (o)
      4'h1: v.ram_wren = 1;
      4'h4: v.pc_sload = 1;
      4'h5: v.pc_sload = mi;
      4'h6: v.pc_sload = eq;
      4'h8: begin v.mux2_sel = 1; v.sr_en = 1; v.sr_load = 1; end
      4'h9, 4'hA: if (sa != 0) begin v.sr_en = 1; v.sr_dir = (o == 4'hA); end
      default: ;
    endcase
    step(v, "exec1");

    if (o == 4'h0 || o == 4'h2 || o == 4'h3) begin
      EQ = 1'($urandom); MI = 1'($urandom); run = 1'($urandom);
      v = '0; v.exec2 = 1; v.sr_en = 1; v.sr_load = 1;
      v.mux3_sel = (o != 4'h0); v.alu_add_sub = (o == 4'h2);
      step(v, "exec2");
    end else if (is_sh && sa >= 2) begin
      for (int k = 1; k < int'(sa); k++) begin
        EQ = 1'($urandom); MI = 1'($urandom); run = 1'($urandom);
        if (k == rst_at) begin
          rst = 1'b1;
          run = 1'b0;
          exp_ill = 1'b0;
          step(halt_v(), "rst_mid_shift");
          rst = 1'b0;
          leave_halt();
          return;
        end
        v = '0; v.shifting = 1; v.sr_en = 1; v.sr_dir = (o == 4'hA);
        step(v, "shift");
      end
    end else if (o == 4'h7) begin
      leave_halt();
    end else if (o > 4'hA) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      exp_ill = 1'b1;
      leave_halt();
`endif
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; op = '0; shamt = '0; EQ = 1'b0; MI = 1'b0;
    @(posedge clk);
    #1;
    step(halt_v(), "reset0");
    run = 1'b1;
    step(halt_v(), "reset1_run_ignored");
    rst = 1'b0;
    run = 1'b0;
    step(halt_v(), "post_reset");
    leave_halt();

    do_instr(4'h0, 4'h3, 1'b0, 1'b0, 0);   // LDA
    do_instr(4'h2, 4'h0, 1'b1, 1'b1, 0);   // ADD
    do_instr(4'h3, 4'h0, 1'b0, 1'b1, 0);   // SUB
    do_instr(4'h6, 4'h0, 1'b0, 1'b1, 0);   // JEQ not taken
    do_instr(4'h6, 4'h0, 1'b1, 1'b0, 0);   // JEQ taken
    do_instr(4'h5, 4'h0, 1'b0, 1'b1, 0);   // JMI taken
    do_instr(4'h5, 4'h0, 1'b1, 1'b0, 0);   // JMI not taken
    do_instr(4'h4, 4'h0, 1'b0, 1'b0, 0);   // JMP
    do_instr(4'h1, 4'h0, 1'b0, 1'b0, 0);   // STA
    do_instr(4'h8, 4'h7, 1'b0, 1'b0, 0);   // LDI
    do_instr(4'hA, 4'h5, 1'b0, 1'b0, 0);   // LSR 5
    do_instr(4'h9, 4'h0, 1'b0, 1'b0, 0);   // LSL 0
    do_instr(4'hA, 4'h1, 1'b0, 1'b0, 0);   // LSR 1
    do_instr(4'h9, 4'h2, 1'b0, 1'b0, 0);   // LSL 2
    do_instr(4'h9, 4'hF, 1'b0, 1'b0, 0);   // LSL max
    do_instr(4'hA, 4'h6, 1'b0, 1'b0, 3);   // reset on SHIFT with cnt = 3
    do_instr(4'h7, 4'h0, 1'b0, 1'b0, 0);   // STP
    do_instr(4'hC, 4'h0, 1'b0, 1'b0, 0);   // illegal
    do_instr(4'hF, 4'h3, 1'b1, 1'b1, 0);   // illegal

    for (int n = 0; n < 300; n++) begin
      do_instr(4'($urandom_range(0, 15)), 4'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
